// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions for the EX-stage multiply/divide units.
// Holds func3 encodings, divider state type and operand constants.
package muldiv_pkg;

  localparam logic [2:0] FUNC3_DIV  = 3'b100;
  localparam logic [2:0] FUNC3_DIVU = 3'b101;
  localparam logic [2:0] FUNC3_REM  = 3'b110;
  localparam logic [2:0] FUNC3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(
    input logic [31:0] x,
    input logic        sgn
  );
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the divider.
// Same shape as the multiplier's operand interface.
interface div_iter_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_stall;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op_out;

  modport master (
    output op_valid, op_stall, op, op1, op2,
    input  op_ready, op_out
  );

  modport slave (
    input  op_valid, op_stall, op, op1, op2,
    output op_ready, op_out
  );
endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step.
// The partial remainder is widened to 33 bits so the trial sign is exact.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shf;
  logic [XLEN:0] trial;

  assign shf   = {rem_i, quo_i[XLEN-1]};
  assign trial = shf - {1'b0, div_i};

  // A negative trial means the divisor did not fit: restore.
  assign rem_o = trial[XLEN] ? shf[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Special cases finish in one cycle, others take 32 steps.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  out_q, out_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;

  logic            sgn;
  logic            start;
  logic            dz;
  logic            ovf;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] fix;

  assign sgn   = ~bus.op[0];
  assign start = bus.op_valid & bus.op[2];
  assign dz    = (bus.op2 == '0);
  assign ovf   = sgn & (bus.op1 == INT_MIN)
               & (bus.op2 == ALL_ONES);

  div_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(dvs_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  // Sign fix-up applied to the final step's output.
  always_comb begin
    fix = quo_n;
    if (is_rem_q) begin
      fix = neg_r_q ? -rem_n : rem_n;
    end else begin
      fix = neg_q_q ? -quo_n : quo_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    out_d    = out_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d = bus.op[1];
          neg_q_d  = sgn & (bus.op1[31] ^ bus.op2[31]);
          neg_r_d  = sgn & bus.op1[31];
          rem_d    = '0;
          quo_d    = abs32(bus.op1, sgn);
          dvs_d    = abs32(bus.op2, sgn);
          cnt_d    = '0;
          if (dz) begin
            out_d   = bus.op[1] ? bus.op1 : ALL_ONES;
            state_d = DONE;
          end else if (ovf) begin
            out_d   = bus.op[1] ? '0 : INT_MIN;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          out_d   = fix;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.op_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      out_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      out_q    <= out_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign bus.op_ready = (state_q == DONE);
  assign bus.op_out   = out_q;

endmodule
